serial_adder: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 14 +
 rtl/full_adder_cell.sv | 15 +
 rtl/serial_adder.sv | 105 ++++++++++
 tb/tb_serial_adder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_e        : FSM encodings for the serial adder
//   DEFAULT_WIDTH  : default operand width
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : serial_arith_pkg

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out (majority of the three inputs)
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder. Operands are captured on a start strobe and
// added LSB-first, one bit per clock, through a single full-adder cell.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request, taken when the FSM is not busy shifting
//   a, b           : WIDTH-bit operands, captured on the accepting edge
//   busy           : high while bits are being processed
//   done           : one-cycle pulse when sum/carry_out update
//   sum, carry_out : registered (a + b), held until the next completion
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, acc_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, carry_q, busy_q, done_q;

  logic             s_bit, c_nxt;
  logic [WIDTH-1:0] acc_d;

  full_adder_cell u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (c_q),
    .s    (s_bit),
    .cout (c_nxt)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign acc_d = {s_bit, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        // DONE falls back to IDLE, but a start seen on that edge is taken
        // directly so a held start yields one result every WIDTH+1 cycles.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          acc_q  <= acc_d;
          c_q    <= c_nxt;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= acc_d;
            carry_q <= c_nxt;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk, rst_n, start;
  logic [7:0] a, b;
  logic       busy, done, carry_out;
  logic [7:0] sum;

  int tests, fails;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request and wait (bounded) for done; lat = edges after accept, -1 on timeout.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, output int lat);
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0; a = ~av; b = ~bv;
    lat = -1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (done === 1'b1) begin lat = t; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (sum !== 8'h00) begin fails++; $display("FAIL reset_sum got %h exp 00", sum); end
    tests++; if (carry_out !== 1'b0) begin fails++; $display("FAIL reset_carry got %b exp 0", carry_out); end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry_out !== 1'b0) begin
        fails++;
        $display("FAIL idle_hold cyc %0d got busy=%b done=%b sum=%h c=%b exp 0/0/00/0",
                 i, busy, done, sum, carry_out);
      end
    end
  endtask

  task automatic test_basic();
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0; a = 8'hFF; b = 8'hFF;
    for (int t = 1; t <= 8; t++) begin
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++; $display("FAIL basic_busy edge+%0d got busy=%b done=%b exp 1/0", t - 1, busy, done);
      end
      tick();
    end
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_done got done=%b busy=%b exp 1/0", done, busy); end
    tests++; if (sum !== 8'h96 || carry_out !== 1'b0) begin
      fails++; $display("FAIL basic_sum got %b_%h exp 0_96", carry_out, sum); end
    tick();
    tests++; if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h96) begin
      fails++; $display("FAIL basic_after got done=%b busy=%b sum=%h exp 0/0/96", done, busy, sum); end
  endtask

  task automatic test_overflow();
    int lat;
    do_op(8'hFF, 8'h01, lat);
    tests++; if (lat != 8 || sum !== 8'h00 || carry_out !== 1'b1) begin
      fails++; $display("FAIL ovf_ff01 got lat=%0d %b_%h exp lat=8 1_00", lat, carry_out, sum); end
    do_op(8'hFF, 8'hFF, lat);
    tests++; if (lat != 8 || sum !== 8'hFE || carry_out !== 1'b1) begin
      fails++; $display("FAIL ovf_ffff got lat=%0d %b_%h exp lat=8 1_fe", lat, carry_out, sum); end
    tick();
  endtask

  task automatic test_ignored_start();
    int ndone;
    a = 8'h10; b = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    a = 8'hAA; b = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int t = 0; t < 20; t++) begin
      if (done === 1'b1) begin
        ndone++;
        tests++; if (sum !== 8'h30 || carry_out !== 1'b0) begin
          fails++; $display("FAIL ign_sum got %b_%h exp 0_30", carry_out, sum); end
      end
      tick();
    end
    tests++; if (ndone != 1) begin fails++; $display("FAIL ign_count got %0d dones exp 1", ndone); end
    tests++; if (busy !== 1'b0 || sum !== 8'h30) begin
      fails++; $display("FAIL ign_idle got busy=%b sum=%h exp 0/30", busy, sum); end
  endtask

  task automatic test_reset_mid();
    int lat;
    a = 8'h80; b = 8'h80; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy got %b exp 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry_out !== 1'b0) begin
      fails++; $display("FAIL mid_reset got busy=%b done=%b sum=%h c=%b exp 0/0/00/0",
                        busy, done, sum, carry_out); end
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      tests++; if (done !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL mid_nodone cyc %0d got done=%b busy=%b exp 0/0", t, done, busy); end
    end
    do_op(8'h01, 8'h02, lat);
    tests++; if (lat != 8 || sum !== 8'h03 || carry_out !== 1'b0) begin
      fails++; $display("FAIL mid_next got lat=%0d %b_%h exp lat=8 0_03", lat, carry_out, sum); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [4] = '{8'h12, 8'hF0, 8'h7F, 8'hC8};
    logic [7:0] vb [4] = '{8'h34, 8'h20, 8'h01, 8'h64};
    logic [8:0] ref_v;
    logic [7:0] held;
    a = va[0]; b = vb[0]; start = 1'b1;
    tick();
    held = sum;
    for (int j = 0; j < 4; j++) begin
      if (j < 3) begin a = va[j+1]; b = vb[j+1]; end
      else start = 1'b0;
      ref_v = {1'b0, va[j]} + {1'b0, vb[j]};
      for (int t = 1; t <= 8; t++) begin
        tick();
        if (t < 8) begin
          tests++; if (done !== 1'b0 || sum !== held) begin
            fails++; $display("FAIL b2b_hold op%0d t%0d got done=%b sum=%h exp 0/%h", j, t, done, sum, held); end
        end else begin
          tests++; if (done !== 1'b1 || sum !== ref_v[7:0] || carry_out !== ref_v[8]) begin
            fails++; $display("FAIL b2b_done op%0d got done=%b %b_%h exp 1 %b_%h",
                              j, done, carry_out, sum, ref_v[8], ref_v[7:0]); end
          held = ref_v[7:0];
        end
      end
      tick();
      tests++; if (done !== 1'b0 || busy !== (j < 3) || sum !== held) begin
        fails++; $display("FAIL b2b_next op%0d got done=%b busy=%b sum=%h exp 0/%b/%h",
                          j, done, busy, sum, (j < 3), held); end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_serial_adder
